// File: rtl/bc_mlp_pkg.sv
// Shared sizes, types and trained weight set for the printed breast-cancer MLP.
package bc_mlp_pkg;

    localparam int NUM_A    = 10;
    localparam int WIDTH_A  = 4;
    localparam int OUTWIDTH = 2;
    localparam int NUM_H    = 4;
    localparam int NUM_C    = 2;
    localparam int WW       = 8;

    localparam int HW    = WW + 2;
    localparam int HACCW = 18;
    localparam int OACCW = 24;

    localparam int W1W = NUM_H * NUM_A * WW;
    localparam int B1W = NUM_H * WW;
    localparam int W2W = NUM_C * NUM_H * WW;
    localparam int B2W = NUM_C * WW;

    typedef logic [WIDTH_A-1:0]      feat_t;
    typedef logic [HW-1:0]           hid_t;
    typedef logic signed [OACCW-1:0] acc_t;

    // Element [j][i] sits at bits (j*NUM_A+i)*WW; leftmost byte is the highest index.
    localparam logic [W1W-1:0] W1 = {
        80'hf3_07_fe_11_05_e9_0c_02_fa_09,
        80'h04_f8_13_fd_0a_06_ee_01_0e_f5,
        80'h0b_02_f7_08_f1_0d_03_fc_07_12,
        80'hfa_10_05_f2_09_01_0f_f6_04_0c
    };
    localparam logic [B1W-1:0] B1 = {8'hf8, 8'h05, 8'hfd, 8'h0a};
    localparam logic [W2W-1:0] W2 = {
        32'h0e_f9_0b_f4,
        32'hf2_07_f5_0c
    };
    localparam logic [B2W-1:0] B2 = {8'hfb, 8'h06};

endpackage

// File: rtl/bc_mlp_neuron.sv
// Constant-weight dot product plus bias, with optional ReLU and saturation.
module bc_mlp_neuron #(
    parameter int            N    = 4,
    parameter int            IW   = 4,
    parameter int            ACCW = 18,
    parameter int            OW   = 10,
    parameter int            WW   = 8,
    parameter bit            RELU = 1'b1,
    parameter logic [N*WW-1:0] W  = '0,
    parameter logic [WW-1:0]   B  = '0
) (
    input  logic [N*IW-1:0] x_i,
    output logic [OW-1:0]   y_o
);

    localparam logic signed [ACCW-1:0] SAT_MAX = ACCW'((1 << OW) - 1);

    logic signed [ACCW-1:0] acc;
    logic signed [ACCW-1:0] xs;
    logic signed [ACCW-1:0] ws;

    // Inputs are unsigned codes, so they are zero-extended before the multiply.
    always_comb begin
        acc = ACCW'($signed(B));
        xs  = '0;
        ws  = '0;
        for (int i = 0; i < N; i++) begin
            xs  = ACCW'($signed({1'b0, x_i[i*IW +: IW]}));
            ws  = ACCW'($signed(W[i*WW +: WW]));
            acc = acc + xs * ws;
        end
    end

    if (RELU) begin : g_relu
        always_comb begin
            if (acc[ACCW-1]) begin
                y_o = '0;
            end else if (acc > SAT_MAX) begin
                y_o = '1;
            end else begin
                y_o = acc[OW-1:0];
            end
        end
    end else begin : g_lin
        assign y_o = acc[OW-1:0];
    end

endmodule

// File: rtl/bc_mlp_top.sv
// Two-stage MLP classifier: hidden ReLU layer, then linear output layer and argmax.
module bc_mlp_top
    import bc_mlp_pkg::*;
#(
    parameter logic [W1W-1:0] W1_P = W1,
    parameter logic [B1W-1:0] B1_P = B1,
    parameter logic [W2W-1:0] W2_P = W2,
    parameter logic [B2W-1:0] B2_P = B2
) (
    input  logic                       clk,
    input  logic                       rst_n,
    input  logic                       in_valid,
    input  logic [NUM_A*WIDTH_A-1:0]   inp,
    output logic                       out_valid,
    output logic [OUTWIDTH-1:0]        out
);

    hid_t                h_d [NUM_H];
    hid_t                h_q [NUM_H];
    logic                v1_q;
    logic [NUM_H*HW-1:0] h_flat;
    acc_t                acc_o [NUM_C];
    acc_t                best_acc;
    logic [OUTWIDTH-1:0] cls_d;
    logic [OUTWIDTH-1:0] out_q;
    logic                out_valid_q;

    for (genvar j = 0; j < NUM_H; j++) begin : g_hid
        bc_mlp_neuron #(
            .N    (NUM_A),
            .IW   (WIDTH_A),
            .ACCW (HACCW),
            .OW   (HW),
            .WW   (WW),
            .RELU (1'b1),
            .W    (W1_P[j*NUM_A*WW +: NUM_A*WW]),
            .B    (B1_P[j*WW +: WW])
        ) u_neuron (
            .x_i (inp),
            .y_o (h_d[j])
        );
    end

    // Hidden registers only load on valid samples so X on idle inputs never lands.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            v1_q <= 1'b0;
            for (int j = 0; j < NUM_H; j++) h_q[j] <= '0;
        end else begin
            v1_q <= in_valid;
            if (in_valid) begin
                for (int j = 0; j < NUM_H; j++) h_q[j] <= h_d[j];
            end
        end
    end

    always_comb begin
        h_flat = '0;
        for (int j = 0; j < NUM_H; j++) h_flat[j*HW +: HW] = h_q[j];
    end

    for (genvar c = 0; c < NUM_C; c++) begin : g_out
        bc_mlp_neuron #(
            .N    (NUM_H),
            .IW   (HW),
            .ACCW (OACCW),
            .OW   (OACCW),
            .WW   (WW),
            .RELU (1'b0),
            .W    (W2_P[c*NUM_H*WW +: NUM_H*WW]),
            .B    (B2_P[c*WW +: WW])
        ) u_neuron (
            .x_i (h_flat),
            .y_o (acc_o[c])
        );
    end

    // Strict compare keeps the lowest index on ties.
    always_comb begin
        cls_d    = '0;
        best_acc = acc_o[0];
        for (int c = 1; c < NUM_C; c++) begin
            if (acc_o[c] > best_acc) begin
                best_acc = acc_o[c];
                cls_d    = OUTWIDTH'(c);
            end
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            out_q       <= '0;
            out_valid_q <= 1'b0;
        end else begin
            out_valid_q <= v1_q;
            if (v1_q) out_q <= cls_d;
        end
    end

    assign out       = out_q;
    assign out_valid = out_valid_q;

endmodule

// File: tb/tb_bc_mlp_top.sv
// Directed bench for bc_mlp_top using the all-ones test weight set.
module tb_bc_mlp_top;
    import bc_mlp_pkg::*;

    localparam logic [W1W-1:0] T_W1  = {NUM_H*NUM_A{8'h01}};
    localparam logic [B1W-1:0] T_B1  = '0;
    localparam logic [W2W-1:0] T_W2  = {{NUM_H{8'hff}}, {NUM_H{8'h01}}};
    localparam logic [B2W-1:0] T_B2  = {8'd1, 8'd0};
    localparam logic [B2W-1:0] T_B2T = {8'd1, 8'd1};

    logic                     clk = 1'b0;
    logic                     rst_n;
    logic                     in_valid;
    logic [NUM_A*WIDTH_A-1:0] inp;
    logic                     out_valid;
    logic [OUTWIDTH-1:0]      out;
    logic                     tie_valid;
    logic [OUTWIDTH-1:0]      tie_out;

    int n_cmp = 0;
    int n_mis = 0;

    always #5 clk = ~clk;

    bc_mlp_top #(
        .W1_P (T_W1), .B1_P (T_B1), .W2_P (T_W2), .B2_P (T_B2)
    ) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .in_valid  (in_valid),
        .inp       (inp),
        .out_valid (out_valid),
        .out       (out)
    );

    bc_mlp_top #(
        .W1_P (T_W1), .B1_P (T_B1), .W2_P (T_W2), .B2_P (T_B2T)
    ) dut_tie (
        .clk       (clk),
        .rst_n     (rst_n),
        .in_valid  (in_valid),
        .inp       (inp),
        .out_valid (tie_valid),
        .out       (tie_out)
    );

    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset;
        rst_n    = 1'b0;
        in_valid = 1'b1;
        inp      = {10{4'ha}};
        tick();
        tick();
        n_cmp++;
        if (out !== 2'd0) begin
            n_mis++;
            $display("FAIL reset_out: got %0d want 0", out);
        end
        n_cmp++;
        if (out_valid !== 1'b0) begin
            n_mis++;
            $display("FAIL reset_valid: got %b want 0", out_valid);
        end
        rst_n    = 1'b1;
        in_valid = 1'b0;
        tick();
        tick();
        n_cmp++;
        if (out_valid !== 1'b0) begin
            n_mis++;
            $display("FAIL idle_valid: got %b want 0", out_valid);
        end
    endtask

    task automatic test_zero;
        in_valid = 1'b1;
        inp      = '0;
        tick();
        in_valid = 1'b0;
        n_cmp++;
        if (out_valid !== 1'b0) begin
            n_mis++;
            $display("FAIL zero_lat1_valid: got %b want 0", out_valid);
        end
        tick();
        n_cmp++;
        if (out_valid !== 1'b1) begin
            n_mis++;
            $display("FAIL zero_valid: got %b want 1", out_valid);
        end
        n_cmp++;
        if (out !== 2'd1) begin
            n_mis++;
            $display("FAIL zero_out: got %0d want 1", out);
        end
    endtask

    task automatic test_max;
        in_valid = 1'b1;
        inp      = {10{4'hf}};
        tick();
        in_valid = 1'b0;
        tick();
        n_cmp++;
        if (out_valid !== 1'b1) begin
            n_mis++;
            $display("FAIL max_valid: got %b want 1", out_valid);
        end
        n_cmp++;
        if (out !== 2'd0) begin
            n_mis++;
            $display("FAIL max_out: got %0d want 0", out);
        end
    endtask

    task automatic test_bubble_x;
        in_valid = 1'b0;
        inp      = 'x;
        tick();
        tick();
        n_cmp++;
        if (out_valid !== 1'b0) begin
            n_mis++;
            $display("FAIL bubble_valid: got %b want 0", out_valid);
        end
        n_cmp++;
        if (out !== 2'd0) begin
            n_mis++;
            $display("FAIL bubble_hold: got %0d want 0", out);
        end
    endtask

    task automatic test_back_to_back;
        logic [OUTWIDTH-1:0] exp_out [3] = '{2'd1, 2'd0, 2'd1};
        in_valid = 1'b1;
        inp      = '0;
        tick();
        inp = {10{4'hf}};
        tick();
        for (int k = 0; k < 3; k++) begin
            if (k == 0) inp = '0;
            if (k == 1) in_valid = 1'b0;
            n_cmp++;
            if (out_valid !== 1'b1 || out !== exp_out[k]) begin
                n_mis++;
                $display("FAIL b2b_%0d: got v=%b out=%0d want v=1 out=%0d",
                         k, out_valid, out, exp_out[k]);
            end
            if (k < 2) tick();
        end
        tick();
        n_cmp++;
        if (out_valid !== 1'b0 || out !== 2'd1) begin
            n_mis++;
            $display("FAIL b2b_tail: got v=%b out=%0d want v=0 out=1",
                     out_valid, out);
        end
    endtask

    task automatic test_ramp;
        in_valid = 1'b1;
        for (int i = 0; i < NUM_A; i++) inp[i*WIDTH_A +: WIDTH_A] = WIDTH_A'(i);
        tick();
        in_valid = 1'b0;
        tick();
        n_cmp++;
        if (out_valid !== 1'b1 || out !== 2'd0) begin
            n_mis++;
            $display("FAIL ramp: got v=%b out=%0d want v=1 out=0", out_valid, out);
        end
    endtask

    task automatic test_tie;
        in_valid = 1'b1;
        inp      = '0;
        tick();
        in_valid = 1'b0;
        tick();
        n_cmp++;
        if (tie_valid !== 1'b1 || tie_out !== 2'd0) begin
            n_mis++;
            $display("FAIL tie: got v=%b out=%0d want v=1 out=0", tie_valid, tie_out);
        end
        n_cmp++;
        if (out !== 2'd1) begin
            n_mis++;
            $display("FAIL tie_ref: got %0d want 1", out);
        end
    endtask

    task automatic test_reset_mid;
        in_valid = 1'b1;
        inp      = {10{4'hf}};
        tick();
        in_valid = 1'b0;
        rst_n    = 1'b0;
        tick();
        n_cmp++;
        if (out_valid !== 1'b0 || out !== 2'd0) begin
            n_mis++;
            $display("FAIL rmid_now: got v=%b out=%0d want v=0 out=0", out_valid, out);
        end
        rst_n = 1'b1;
        for (int k = 0; k < 3; k++) begin
            tick();
            n_cmp++;
            if (out_valid !== 1'b0 || out !== 2'd0) begin
                n_mis++;
                $display("FAIL rmid_after_%0d: got v=%b out=%0d want v=0 out=0",
                         k, out_valid, out);
            end
        end
    endtask

    initial begin
        rst_n    = 1'b0;
        in_valid = 1'b0;
        inp      = '0;
        #2;
        test_reset();
        test_zero();
        test_max();
        test_bubble_x();
        test_back_to_back();
        test_ramp();
        test_tie();
        test_reset_mid();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_mis);
        $finish;
    end

endmodule
